// File: rtl/ula_seq_pkg.sv
// Shared definitions for the nibble-serial 74181 word sequencer.
package ula_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // 74181 select codes; SUB and XOR share a code and differ only in mode.
  localparam logic [3:0] SEL_ADD    = 4'b1001;
  localparam logic [3:0] SEL_SUB    = 4'b0110;
  localparam logic [3:0] SEL_XOR    = 4'b0110;
  localparam logic       MODE_LOGIC = 1'b1;
  localparam logic       MODE_ARITH = 1'b0;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ula_74181.sv
// Combinational 4-bit 74181 ALU slice, active-high data, active-low carry in/out.
module ula_74181
  import ula_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic [3:0]       s_i,
  input  logic             m_i,
  input  logic             c_n_i,
  output logic [NIB_W-1:0] f_o,
  output logic             c_n4_o,
  output logic             a_eq_b_o
);

  logic [NIB_W-1:0] term_or;
  logic [NIB_W-1:0] term_and;
  logic [NIB_W:0]   sum;

  // Every 74181 function is term_or plus term_and (arithmetic) or their XNOR (logic).
  always_comb begin
    term_or  = a_i | (b_i & {NIB_W{s_i[0]}}) | (~b_i & {NIB_W{s_i[1]}});
    term_and = (a_i & b_i & {NIB_W{s_i[3]}}) | (a_i & ~b_i & {NIB_W{s_i[2]}});
    sum      = {1'b0, term_or} + {1'b0, term_and} + {{NIB_W{1'b0}}, ~c_n_i};
    f_o      = m_i ? ~(term_or ^ term_and) : sum[NIB_W-1:0];
    c_n4_o   = ~sum[NIB_W];
    a_eq_b_o = &f_o;
  end

endmodule

// File: rtl/ula_serial_seq.sv
// Word ALU that runs one 74181 slice over NIBBLES cycles, LSB nibble first,
// with the slice carry chained through a register; result returned via valid/ready.
module ula_serial_seq
  import ula_seq_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = NIB_W * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_s,
  input  logic             op_m,
  input  logic             op_c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             a_eq_b
);

  localparam int          CW       = cnt_width(NIBBLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             eq_acc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q;
  logic             eq_q;

  logic [NIB_W-1:0] slice_a_d;
  logic [NIB_W-1:0] slice_b_d;
  logic [NIB_W-1:0] slice_f;
  logic             slice_c_n4;
  logic             slice_eq;

  assign slice_a_d = a_q[cnt_q*NIB_W +: NIB_W];
  assign slice_b_d = b_q[cnt_q*NIB_W +: NIB_W];

  ula_74181 u_slice (
    .a_i      (slice_a_d),
    .b_i      (slice_b_d),
    .s_i      (s_q),
    .m_i      (m_q),
    .c_n_i    (carry_q),
    .f_o      (slice_f),
    .c_n4_o   (slice_c_n4),
    .a_eq_b_o (slice_eq)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign carry_out = cout_q;
  assign a_eq_b    = eq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b1;
      eq_acc_q <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      res_q    <= '0;
      cout_q   <= 1'b1;
      eq_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= op_a;
            b_q      <= op_b;
            s_q      <= op_s;
            m_q      <= op_m;
            carry_q  <= op_c_in;
            cnt_q    <= '0;
            eq_acc_q <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          res_q[cnt_q*NIB_W +: NIB_W] <= slice_f;
          carry_q  <= slice_c_n4;
          eq_acc_q <= eq_acc_q & slice_eq;
          if (cnt_q == CNT_LAST) begin
            // Logic mode has no meaningful carry, so report "no carry".
            cout_q  <= m_q | slice_c_n4;
            eq_q    <= eq_acc_q & slice_eq;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_serial_seq.sv
// Scoreboard bench for ula_serial_seq with NIBBLES=4.
module tb_ula_serial_seq;
  import ula_seq_pkg::*;

  localparam int NIB = 4;
  localparam int W   = 16;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         eq;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [3:0]   op_s = '0;
  logic         op_m = 1'b0;
  logic         op_c_in = 1'b1;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out;
  logic         a_eq_b;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ula_serial_seq #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_s      (op_s),
    .op_m      (op_m),
    .op_c_in   (op_c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .a_eq_b    (a_eq_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] s, input logic m, input logic cin_n);
    exp_t         e;
    logic [W:0]   sum;
    if (m) begin
      e.res  = a ^ b;
      e.cout = 1'b1;
    end else begin
      if (s == SEL_ADD) sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ~cin_n};
      else              sum = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin_n} + {1'b1, {W{1'b0}}};
      e.res  = sum[W-1:0];
      e.cout = ~sum[W];
    end
    e.eq = &e.res;
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] s, input logic m, input logic cin_n);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: in_ready=%0b required 1", in_ready);
    end
    op_a = a; op_b = b; op_s = s; op_m = m; op_c_in = cin_n;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic collect(input string name);
    exp_t e;
    exp_t got;
    int   n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%0b required 1", name, out_valid);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: output with empty scoreboard, result=%h", name, result);
    end else begin
      e   = sb.pop_front();
      got = '{res: result, cout: carry_out, eq: a_eq_b};
      if (got !== e) begin
        errors++;
        $display("FAIL %s: result=%h carry_out=%0b a_eq_b=%0b required result=%h carry_out=%0b a_eq_b=%0b",
                 name, got.res, got.cout, got.eq, e.res, e.cout, e.eq);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: in_ready=%0b out_valid=%0b required 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, result, carry_out, a_eq_b} !== {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b result=%h carry_out=%0b a_eq_b=%0b required 1 0 0000 1 0",
               in_ready, out_valid, result, carry_out, a_eq_b);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    sb.push_back('{res: 16'h2201, cout: 1'b1, eq: 1'b0});
    issue(16'h1234, 16'h0FCD, SEL_ADD, MODE_ARITH, 1'b1);
    collect("add_ripple");
    sb.push_back('{res: 16'h0000, cout: 1'b0, eq: 1'b0});
    issue(16'hFFFF, 16'h0001, SEL_ADD, MODE_ARITH, 1'b1);
    collect("add_wrap");
  endtask

  task automatic test_compare();
    sb.push_back('{res: 16'hFFFF, cout: 1'b1, eq: 1'b1});
    issue(16'h5A5A, 16'h5A5A, SEL_SUB, MODE_ARITH, 1'b1);
    collect("cmp_equal");
    sb.push_back('{res: 16'h4949, cout: 1'b0, eq: 1'b0});
    issue(16'h5A5A, 16'h1111, SEL_SUB, MODE_ARITH, 1'b0);
    collect("sub_noborrow");
  endtask

  task automatic test_logic_xor();
    sb.push_back('{res: 16'h0FF0, cout: 1'b1, eq: 1'b0});
    issue(16'hF0F0, 16'hFF00, SEL_XOR, MODE_LOGIC, 1'b1);
    for (int j = 1; j <= NIB; j++) begin
      step();
      checks++;
      if (out_valid !== (j == NIB)) begin
        errors++;
        $display("FAIL xor_latency: edge %0d after accept out_valid=%0b required %0b",
                 j, out_valid, (j == NIB));
      end
    end
    collect("logic_xor");
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n = 0;
    int   phantom = 0;
    e = model(16'hABCD, 16'h1357, SEL_ADD, MODE_ARITH, 1'b0);
    sb.push_back(e);
    issue(16'hABCD, 16'h1357, SEL_ADD, MODE_ARITH, 1'b0);
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        op_a = 16'h1111; op_b = 16'h2222; op_s = SEL_SUB; op_c_in = 1'b0;
        in_valid = 1'b1;
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e.res || carry_out !== e.cout) begin
        errors++;
        $display("FAIL backpressure_hold: cycle %0d out_valid=%0b in_ready=%0b result=%h carry_out=%0b required 1 0 %h %0b",
                 c, out_valid, in_ready, result, carry_out, e.res, e.cout);
      end
    end
    collect("backpressure");
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) phantom++;
    end
    checks++;
    if (phantom != 0) begin
      errors++;
      $display("FAIL backpressure_ignored: out_valid seen %0d cycles required 0", phantom);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   s;
    logic         m;
    logic         cin;
    for (int i = 0; i < 6; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      m   = (i % 3 == 2) ? MODE_LOGIC : MODE_ARITH;
      s   = (i % 3 == 0) ? SEL_ADD : SEL_SUB;
      cin = 1'($urandom_range(0, 1));
      sb.push_back(model(a, b, s, m, cin));
      issue(a, b, s, m, cin);
      collect("back_to_back");
    end
  endtask

  task automatic test_reset_mid_op();
    issue(16'h1234, 16'h4321, SEL_ADD, MODE_ARITH, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_op: out_valid=%0b in_ready=%0b result=%h required 0 1 0000",
               out_valid, in_ready, result);
    end
    step();
    rst_n = 1'b1;
    step();
    sb.push_back('{res: 16'h0002, cout: 1'b1, eq: 1'b0});
    issue(16'h0001, 16'h0001, SEL_ADD, MODE_ARITH, 1'b1);
    collect("after_reset_add");
  endtask

  initial begin
    test_reset();
    test_add();
    test_compare();
    test_logic_xor();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
